// File: rtl/bti_mux_if.sv
// bti_mux_if: BTI request and response channel interfaces.
// bti_req_if_t carries vld/rdy plus an opaque request packet (addr, data, we, tid);
// bti_rsp_if_t carries vld/rdy plus the response packet (tid, data, ok).
// The mst modport drives vld and the packet; the slv modport drives rdy.
interface bti_req_if_t #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIDW = 4
);
    logic            vld;
    logic            rdy;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic            we;
    logic [TIDW-1:0] tid;
    modport mst (output vld, addr, data, we, tid, input rdy);
    modport slv (input vld, addr, data, we, tid, output rdy);
endinterface

interface bti_rsp_if_t #(
    parameter int DW = 32,
    parameter int TIDW = 4
);
    logic            vld;
    logic            rdy;
    logic [TIDW-1:0] tid;
    logic [DW-1:0]   data;
    logic            ok;
    modport mst (output vld, tid, data, ok, input rdy);
    modport slv (input vld, tid, data, ok, output rdy);
endinterface

// File: rtl/bti_mux.sv
// bti_mux: N-to-1 BTI initiator multiplexer with one outstanding transaction.
// Ports: clk, rst_n (async active-low); host_bti_req_slvs[HST_NUM] host requests in;
// host_bti_rsp_msts[HST_NUM] host responses out; gst_bti_req_mst merged request out;
// gst_bti_rsp_slv guest response in.
// Macro BTI_MUX_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module bti_mux #(
    parameter int BTI_AW = 32,
    parameter int BTI_DW = 32,
    parameter int BTI_TIDW = 4,
    parameter int HST_NUM = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    bti_req_if_t.slv host_bti_req_slvs [HST_NUM],
    bti_rsp_if_t.mst host_bti_rsp_msts [HST_NUM],
    bti_req_if_t.mst gst_bti_req_mst,
    bti_rsp_if_t.slv gst_bti_rsp_slv
);
    localparam int HST_IDW = $clog2(HST_NUM);
    typedef enum logic [1:0] {IDLE, HOLD, PEND} st_t;
    st_t                 st, st_nxt;
    logic [HST_IDW-1:0]  owner, gnt_q, win, gnt;
    logic [HST_NUM-1:0]  h_vld, h_we, h_rsp_rdy;
    logic [BTI_AW-1:0]   h_addr [HST_NUM];
    logic [BTI_DW-1:0]   h_data [HST_NUM];
    logic [BTI_TIDW-1:0] h_tid  [HST_NUM];
    logic                rsp_rdy, rsp_hsk, issue_ok, req_vld, req_hsk;

    for (genvar i = 0; i < HST_NUM; i++) begin : g_host
        assign h_vld[i]  = host_bti_req_slvs[i].vld;
        assign h_we[i]   = host_bti_req_slvs[i].we;
        assign h_addr[i] = host_bti_req_slvs[i].addr;
        assign h_data[i] = host_bti_req_slvs[i].data;
        assign h_tid[i]  = host_bti_req_slvs[i].tid;
        // rdy only reaches the granted, requesting host
        assign host_bti_req_slvs[i].rdy = req_vld & gst_bti_req_mst.rdy & (gnt == HST_IDW'(i));
        assign host_bti_rsp_msts[i].vld  = gst_bti_rsp_slv.vld & (st == PEND) & (owner == HST_IDW'(i));
        assign host_bti_rsp_msts[i].tid  = gst_bti_rsp_slv.tid;
        assign host_bti_rsp_msts[i].data = gst_bti_rsp_slv.data;
        assign host_bti_rsp_msts[i].ok   = gst_bti_rsp_slv.ok;
        assign h_rsp_rdy[i] = host_bti_rsp_msts[i].rdy;
    end

`ifdef BTI_MUX_RR_EN
    logic [HST_IDW-1:0] rr_ptr;
    logic [HST_IDW:0]   idx;
    // Scan from the far end so the host closest to rr_ptr is written last and wins
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = HST_NUM - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (HST_IDW+1)'(k);
            idx = (idx >= (HST_IDW+1)'(HST_NUM)) ? idx - (HST_IDW+1)'(HST_NUM) : idx;
            win = h_vld[idx[HST_IDW-1:0]] ? idx[HST_IDW-1:0] : win;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= '0;
        else if (req_hsk) rr_ptr <= (gnt == HST_IDW'(HST_NUM - 1)) ? '0 : gnt + 1'b1;
    end
`else
    always_comb begin
        win = '0;
        for (int k = HST_NUM - 1; k >= 0; k--) win = h_vld[k] ? HST_IDW'(k) : win;
    end
`endif

    // A new request may issue while idle/locked, or in the cycle the pending response retires
    assign rsp_rdy  = (st == PEND) & h_rsp_rdy[owner];
    assign rsp_hsk  = gst_bti_rsp_slv.vld & rsp_rdy;
    assign issue_ok = (st != PEND) | rsp_hsk;
    assign gnt      = (st == HOLD) ? gnt_q : win;
    assign req_vld  = rst_n & issue_ok & h_vld[gnt];
    assign req_hsk  = req_vld & gst_bti_req_mst.rdy;

    assign gst_bti_req_mst.vld  = req_vld;
    assign gst_bti_req_mst.addr = h_addr[gnt];
    assign gst_bti_req_mst.data = h_data[gnt];
    assign gst_bti_req_mst.we   = h_we[gnt];
    assign gst_bti_req_mst.tid  = h_tid[gnt];
    assign gst_bti_rsp_slv.rdy  = rsp_rdy;

    always_comb begin
        st_nxt = req_hsk ? PEND : req_vld ? HOLD : (st == PEND && rsp_hsk) ? IDLE : st;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= IDLE;
            owner <= '0;
            gnt_q <= '0;
        end else begin
            st <= st_nxt;
            if (req_hsk) owner <= gnt;
            if (req_vld && !gst_bti_req_mst.rdy) gnt_q <= gnt;
        end
    end
endmodule

// File: tb/tb_bti_mux.sv
// tb_bti_mux: directed scenarios plus randomized traffic against a transaction-level model of bti_mux.
module tb_bti_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bti_req_if_t #(.AW(32), .DW(32), .TIDW(4)) hreq [3] ();
    bti_rsp_if_t #(.DW(32), .TIDW(4))          hrsp [3] ();
    bti_req_if_t #(.AW(32), .DW(32), .TIDW(4)) greq ();
    bti_rsp_if_t #(.DW(32), .TIDW(4))          grsp ();

    logic [2:0]  h_vld = '0, h_we = '0, h_rdy, hr_vld, hr_rdy = '0, hr_ok;
    logic [31:0] h_addr [3], h_data [3], hr_data [3];
    logic [3:0]  h_tid [3], hr_tid [3];
    logic        g_vld, g_rdy = 1'b0, g_we, gr_vld = 1'b0, gr_ok = 1'b0, gr_rdy;
    logic [31:0] g_addr, g_data, gr_data = '0;
    logic [3:0]  g_tid, gr_tid = '0;

    for (genvar i = 0; i < 3; i++) begin : g_w
        assign hreq[i].vld  = h_vld[i];
        assign hreq[i].addr = h_addr[i];
        assign hreq[i].data = h_data[i];
        assign hreq[i].we   = h_we[i];
        assign hreq[i].tid  = h_tid[i];
        assign h_rdy[i]     = hreq[i].rdy;
        assign hr_vld[i]    = hrsp[i].vld;
        assign hr_tid[i]    = hrsp[i].tid;
        assign hr_data[i]   = hrsp[i].data;
        assign hr_ok[i]     = hrsp[i].ok;
        assign hrsp[i].rdy  = hr_rdy[i];
    end
    assign g_vld    = greq.vld;
    assign g_addr   = greq.addr;
    assign g_data   = greq.data;
    assign g_we     = greq.we;
    assign g_tid    = greq.tid;
    assign greq.rdy = g_rdy;
    assign grsp.vld  = gr_vld;
    assign grsp.tid  = gr_tid;
    assign grsp.data = gr_data;
    assign grsp.ok   = gr_ok;
    assign gr_rdy    = grsp.rdy;

    bti_mux #(.BTI_AW(32), .BTI_DW(32), .BTI_TIDW(4), .HST_NUM(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .host_bti_req_slvs(hreq),
        .host_bti_rsp_msts(hrsp),
        .gst_bti_req_mst(greq),
        .gst_bti_rsp_slv(grsp)
    );

`ifdef BTI_MUX_RR_EN
    localparam logic [1:0] B2B = 2'd2, X = 2'd0;
`else
    localparam logic [1:0] B2B = 2'd0, X = 2'd2;
`endif

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] oh(input logic [1:0] i);
        return 3'(3'b1 << i);
    endfunction

    // Arbitration rule: round-robin starting at p, or lowest index when fixed priority
    function automatic logic [1:0] arb(input logic [2:0] m, input logic [1:0] p);
        logic [1:0] w = '0;
`ifdef BTI_MUX_RR_EN
        for (int k = 2; k >= 0; k--) if (m[(int'(p) + k) % 3]) w = 2'((int'(p) + k) % 3);
`else
        for (int k = 2; k >= 0; k--) if (m[k] || p > 2'd3) w = 2'(k);
`endif
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic new_pkt(input int i);
        h_addr[i] = $urandom;
        h_data[i] = $urandom;
        h_we[i]   = 1'($urandom);
        h_tid[i]  = 4'($urandom);
        h_vld[i]  = 1'b1;
    endtask

    // transaction-level model and guest BFM state
    logic       m_out, m_lock, rsp_hsk, ev, any, g_pend;
    logic [1:0] m_own, m_ptr, m_lk, win;
    logic [3:0] exp_tid [3];
    logic [3:0] g_ptid;
    logic [2:0] s_hrdy;
    logic       s_grdy, s_reqhsk;
    logic [3:0] s_gtid;
    int         g_dly;

    initial begin
        for (int i = 0; i < 3; i++) begin
            h_addr[i] = '0;
            h_data[i] = '0;
            h_tid[i]  = '0;
        end
        #1;
        for (int i = 0; i < 3; i++) new_pkt(i);
        g_rdy = 1'b1; gr_vld = 1'b1; hr_rdy = 3'b111;
        #2;
        chk("rst_gvld", g_vld, 0);
        chk("rst_hrdy", h_rdy, 0);
        chk("rst_hrvld", hr_vld, 0);
        chk("rst_grrdy", gr_rdy, 0);
        h_vld = '0; gr_vld = 1'b0; g_rdy = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        new_pkt(0); new_pkt(2); g_rdy = 1'b1; hr_rdy = 3'b111;
        #2;
        chk("arb_first", h_rdy, 3'b001);
        chk("arb_gvld", g_vld, 1);
        chk("arb_pkt", {g_addr, g_data, g_tid}, {h_addr[0], h_data[0], h_tid[0]});
        cyc();
        h_vld[0] = 1'b0;
        #2;
        chk("pend_gvld", g_vld, 0);
        chk("pend_hrdy", h_rdy, 0);
        cyc();
        new_pkt(0);
        gr_vld = 1'b1; gr_tid = 4'd5; gr_data = 32'hDEADBEEF; gr_ok = 1'b1;
        #2;
        chk("rsp_route", hr_vld, 3'b001);
        chk("rsp_grrdy", gr_rdy, 1);
        chk("rsp_pkt", {hr_tid[0], hr_data[0], hr_ok[0]}, {4'd5, 32'hDEADBEEF, 1'b1});
        chk("b2b_hrdy", h_rdy, oh(B2B));
        cyc();
        h_vld[B2B] = 1'b0; gr_vld = 1'b0;
        #2;
        chk("b2b_pend", g_vld, 0);
        cyc();
        gr_vld = 1'b1; g_rdy = 1'b0; hr_rdy = 3'b000;
        #2;
        chk("stall_grrdy", gr_rdy, 0);
        chk("stall_hrvld", hr_vld, oh(B2B));
        chk("stall_gvld", g_vld, 0);
        chk("bcast_data", hr_data[X], 32'hDEADBEEF);
        cyc();
        hr_rdy = 3'b111;
        #2;
        chk("unstall_grrdy", gr_rdy, 1);
        chk("lock_gvld", g_vld, 1);
        chk("lock_hrdy", h_rdy, 0);
        cyc();
        gr_vld = 1'b0;
        new_pkt(1);
        #2;
        chk("hold_gvld", g_vld, 1);
        chk("hold_addr", g_addr, h_addr[X]);
        chk("hold_hrdy", h_rdy, 0);
        cyc();
        #2;
        chk("hold2_addr", g_addr, h_addr[X]);
        cyc();
        g_rdy = 1'b1;
        #2;
        chk("hold_rel", h_rdy, oh(X));
        cyc();
        h_vld[X] = 1'b0;
        gr_vld = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_gvld", g_vld, 0);
        chk("arst_hrdy", h_rdy, 0);
        chk("arst_hrvld", hr_vld, 0);
        chk("arst_grrdy", gr_rdy, 0);
        cyc();
        rst_n = 1'b1;
        h_vld[1] = 1'b0;
        #2;
        chk("idle_grrdy", gr_rdy, 0);
        chk("idle_hrvld", hr_vld, 0);
        cyc();

        new_pkt(1); new_pkt(2);
        for (int c = 0; c < 6; c++) begin
            #2;
`ifdef BTI_MUX_RR_EN
            chk("prio", h_rdy, (c % 2 == 1) ? 3'b100 : 3'b010);
`else
            chk("prio", h_rdy, 3'b010);
`endif
            s_hrdy = h_rdy;
            cyc();
            for (int i = 1; i < 3; i++) if (s_hrdy[i]) new_pkt(i);
        end

        h_vld = '0; gr_vld = 1'b0; g_rdy = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        m_out = 0; m_lock = 0; m_own = 0; m_ptr = 0; m_lk = 0; g_pend = 0; g_dly = 0; g_ptid = 0;
        for (int i = 0; i < 3; i++) exp_tid[i] = '0;
        for (int c = 0; c < 1500; c++) begin
            #2;
            rsp_hsk = m_out && gr_vld && hr_rdy[m_own];
            win = m_lock ? m_lk : arb(h_vld, m_ptr);
            any = m_lock ? h_vld[m_lk] : |h_vld;
            ev  = (!m_out || rsp_hsk) && any;
            chk("r_gvld", g_vld, ev);
            chk("r_grrdy", gr_rdy, m_out && hr_rdy[m_own]);
            chk("r_hrvld", hr_vld, (m_out && gr_vld) ? oh(m_own) : 3'b000);
            chk("r_hrdy", h_rdy, (ev && g_rdy) ? oh(win) : 3'b000);
            if (ev) chk("r_pkt", {g_addr, g_data, g_we, g_tid}, {h_addr[win], h_data[win], h_we[win], h_tid[win]});
            if (rsp_hsk) chk("r_rtid", {hr_tid[m_own], hr_data[m_own]}, {exp_tid[m_own], gr_data});
            if (rsp_hsk) m_out = 0;
            if (ev && g_rdy) begin
                m_out = 1; m_own = win; m_lock = 0;
                m_ptr = 2'((int'(win) + 1) % 3);
                exp_tid[win] = h_tid[win];
            end else if (ev) begin
                m_lock = 1; m_lk = win;
            end
            s_hrdy = h_rdy; s_grdy = gr_rdy; s_gtid = g_tid; s_reqhsk = g_vld && g_rdy;
            cyc();
            for (int i = 0; i < 3; i++) begin
                if (h_vld[i] && s_hrdy[i]) h_vld[i] = 1'b0;
                if (!h_vld[i] && $urandom_range(3) != 0) new_pkt(i);
            end
            if (gr_vld && s_grdy) gr_vld = 1'b0;
            if (s_reqhsk) begin
                g_pend = 1; g_ptid = s_gtid; g_dly = $urandom_range(2);
            end
            if (g_pend && !gr_vld) begin
                if (g_dly == 0) begin
                    gr_vld = 1'b1; gr_tid = g_ptid; gr_data = $urandom; gr_ok = 1'($urandom); g_pend = 0;
                end else g_dly--;
            end
            g_rdy  = $urandom_range(2) != 0;
            hr_rdy = 3'($urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
